// File: rtl/secded_scrubber.sv
// Background scrubber that walks a hamming_secded protected memory, writes back corrected words and logs errors.
// Optional SCRUB_HALT_ON_UE_EN: park in HALT after an uncorrectable error until clr_i.
module secded_scrubber #(
  parameter int K        = 4,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int INTERVAL = 256,
  parameter int CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              start_i,
  input  logic              clr_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [K-1:0]      mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [K-1:0]      dec_data_i,
  input  logic              dec_1bit_err_i,
  input  logic              dec_2bit_err_i,
  output logic              busy_o,
  output logic              pass_done_o,
  output logic [CNT_W-1:0]  ce_cnt_o,
  output logic [CNT_W-1:0]  ue_cnt_o,
  output logic [ADDR_W-1:0] ue_addr_o,
  output logic              ue_valid_o,
  output logic              irq_o
);

  localparam int                IVL_W     = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [IVL_W-1:0]  IVL_LOAD  = IVL_W'(INTERVAL - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RD_REQ,
    S_RD_RESP,
    S_WR_REQ,
    S_NEXT
`ifdef SCRUB_HALT_ON_UE_EN
    , S_HALT
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [IVL_W-1:0]   ival_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [K-1:0]       wdata_q;
  logic [CNT_W-1:0]   ce_q, ue_q;
  logic [ADDR_W-1:0]  ue_addr_q;
  logic               ue_valid_q;
  logic               last, rd_done, ue_evt, ce_evt;

  // Counters stick at all-ones rather than wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign last    = (addr_q == LAST_ADDR);
  assign rd_done = (state_q == S_RD_RESP) && mem_rvalid_i;
  assign ue_evt  = rd_done && dec_2bit_err_i;
  assign ce_evt  = rd_done && dec_1bit_err_i && !dec_2bit_err_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (en_i) state_d = S_WAIT;
      S_WAIT: begin
        if (!en_i)                          state_d = S_IDLE;
        else if (start_i || ival_q == '0)   state_d = S_RD_REQ;
      end
      S_RD_REQ:  if (mem_gnt_i) state_d = S_RD_RESP;
      S_RD_RESP: begin
        if (mem_rvalid_i) begin
          if (dec_2bit_err_i)
`ifdef SCRUB_HALT_ON_UE_EN
            state_d = S_HALT;
`else
            state_d = S_NEXT;
`endif
          else if (dec_1bit_err_i) state_d = S_WR_REQ;
          else                     state_d = S_NEXT;
        end
      end
      S_WR_REQ:  if (mem_gnt_i) state_d = S_NEXT;
      S_NEXT: begin
        if (!en_i)     state_d = S_IDLE;
        else if (last) state_d = S_WAIT;
        else           state_d = S_RD_REQ;
      end
`ifdef SCRUB_HALT_ON_UE_EN
      // Resuming through NEXT keeps the wrap and disable handling in one place.
      S_HALT:    if (clr_i) state_d = S_NEXT;
`endif
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    busy_o      = 1'b0;
    pass_done_o = 1'b0;
    case (state_q)
      S_RD_REQ: begin
        mem_req_o = 1'b1;
        busy_o    = 1'b1;
      end
      S_RD_RESP: busy_o = 1'b1;
      S_WR_REQ: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        busy_o    = 1'b1;
      end
      S_NEXT: begin
        busy_o      = 1'b1;
        pass_done_o = en_i && last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ival_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      if (state_d == S_WAIT && state_q != S_WAIT) ival_q <= IVL_LOAD;
      else if (state_q == S_WAIT && ival_q != '0) ival_q <= ival_q - IVL_W'(1);
      if (state_q == S_NEXT) addr_q <= (!en_i || last) ? '0 : addr_q + ADDR_W'(1);
      if (ce_evt) wdata_q <= dec_data_i;
    end
  end

  // Clear wins over a same-cycle error event; that event is dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ce_q       <= '0;
      ue_q       <= '0;
      ue_addr_q  <= '0;
      ue_valid_q <= 1'b0;
    end else if (clr_i) begin
      ce_q       <= '0;
      ue_q       <= '0;
      ue_addr_q  <= '0;
      ue_valid_q <= 1'b0;
    end else begin
      if (ce_evt) ce_q <= sat_inc(ce_q);
      if (ue_evt) begin
        ue_q <= sat_inc(ue_q);
        if (!ue_valid_q) begin
          ue_addr_q  <= addr_q;
          ue_valid_q <= 1'b1;
        end
      end
    end
  end

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign ce_cnt_o    = ce_q;
  assign ue_cnt_o    = ue_q;
  assign ue_addr_o   = ue_addr_q;
  assign ue_valid_o  = ue_valid_q;
  assign irq_o       = ue_valid_q;

endmodule

// File: tb/tb_secded_scrubber.sv
// Directed bench for secded_scrubber: a small memory/decoder responder plus hand-computed expectations.
module tb_secded_scrubber;

  localparam int K        = 4;
  localparam int DEPTH    = 16;
  localparam int ADDR_W   = 4;
  localparam int INTERVAL = 4;
  localparam int CNT_W    = 2;

  logic              clk = 1'b0;
  logic              rst_ni = 1'b0;
  logic              en_i = 1'b0, start_i = 1'b0, clr_i = 1'b0;
  logic              mem_req_o, mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [K-1:0]      mem_wdata_o;
  logic              mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [K-1:0]      dec_data_i;
  logic              dec_1bit_err_i, dec_2bit_err_i;
  logic              busy_o, pass_done_o;
  logic [CNT_W-1:0]  ce_cnt_o, ue_cnt_o;
  logic [ADDR_W-1:0] ue_addr_o;
  logic              ue_valid_o, irq_o;

  secded_scrubber #(
    .K(K), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .INTERVAL(INTERVAL), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i), .start_i(start_i), .clr_i(clr_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .dec_data_i(dec_data_i), .dec_1bit_err_i(dec_1bit_err_i), .dec_2bit_err_i(dec_2bit_err_i),
    .busy_o(busy_o), .pass_done_o(pass_done_o), .ce_cnt_o(ce_cnt_o), .ue_cnt_o(ue_cnt_o),
    .ue_addr_o(ue_addr_o), .ue_valid_o(ue_valid_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  // Error injection tables, indexed by the address of the read being answered.
  logic [15:0]  err1 = '0, err2 = '0;
  logic [K-1:0] fix_data [16];
  logic [3:0]   resp_addr = '0, pend_addr = '0;
  logic         pend_rd = 1'b0;
  int           wait_cnt = 0, gnt_wait = 0;

  assign dec_1bit_err_i = mem_rvalid_i && err1[resp_addr];
  assign dec_2bit_err_i = mem_rvalid_i && err2[resp_addr];
  assign dec_data_i     = fix_data[resp_addr];

  int          n_tests = 0, n_fail = 0;
  int          rd_cnt, wr_cnt, pd_cnt, stall_cnt, stab_err, seq_err;
  logic [3:0]  rd_first, rd_prev, wr_addr, wr_data, nxt_addr;
  logic        prev_req = 1'b0, prev_gnt = 1'b0, prev_we = 1'b0;
  logic [3:0]  prev_addr = '0, prev_wdata = '0;
  bit          found;

  // Responder and monitor: inputs change mid-cycle, DUT samples them at the next rising edge.
  always @(negedge clk) begin
    mem_rvalid_i = pend_rd;
    resp_addr    = pend_addr;
    if (mem_req_o) begin
      mem_gnt_i = (wait_cnt >= gnt_wait);
      wait_cnt  = mem_gnt_i ? 0 : wait_cnt + 1;
    end else begin
      mem_gnt_i = 1'b0;
      wait_cnt  = 0;
    end
    pend_rd   = mem_req_o && !mem_we_o && mem_gnt_i;
    pend_addr = mem_addr_o;
    if (prev_req && !prev_gnt &&
        (!mem_req_o || mem_we_o !== prev_we || mem_addr_o !== prev_addr || mem_wdata_o !== prev_wdata))
      stab_err++;
    if (mem_req_o && !mem_gnt_i) stall_cnt++;
    if (mem_req_o && mem_gnt_i) begin
      if (mem_we_o) begin
        wr_cnt++;
        wr_addr = mem_addr_o;
        wr_data = mem_wdata_o;
      end else begin
        nxt_addr = rd_prev + 4'd1;
        if (rd_cnt == 0) rd_first = mem_addr_o;
        else if (mem_addr_o != nxt_addr) seq_err++;
        rd_prev = mem_addr_o;
        rd_cnt++;
      end
    end
    if (pass_done_o) pd_cnt++;
    prev_req   = mem_req_o;
    prev_gnt   = mem_gnt_i;
    prev_we    = mem_we_o;
    prev_addr  = mem_addr_o;
    prev_wdata = mem_wdata_o;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_log();
    rd_cnt = 0; wr_cnt = 0; pd_cnt = 0; stall_cnt = 0; stab_err = 0; seq_err = 0;
    rd_first = '0; rd_prev = '0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic wait_pass(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      seen = pass_done_o;
    end
    check({tag, "_pass_done"}, 32'(seen), 32'd1);
  endtask

  // Called on the NEXT cycle of a wrap; drops en_i while the FSM sits in WAIT.
  task automatic go_idle();
    @(negedge clk);
    en_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_for_write(input string tag);
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      found = mem_req_o && mem_we_o;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) fix_data[i] = '0;
    clear_log();
    repeat (3) @(negedge clk);
    check("rst_req",      32'(mem_req_o),   32'd0);
    check("rst_we",       32'(mem_we_o),    32'd0);
    check("rst_addr",     32'(mem_addr_o),  32'd0);
    check("rst_busy",     32'(busy_o),      32'd0);
    check("rst_ce",       32'(ce_cnt_o),    32'd0);
    check("rst_ue",       32'(ue_cnt_o),    32'd0);
    check("rst_ue_valid", 32'(ue_valid_o),  32'd0);
    check("rst_irq",      32'(irq_o),       32'd0);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_req",  32'(mem_req_o),   32'd0);

    // Clean pass
    clear_log();
    en_i = 1'b1;
    wait_pass("clean");
    go_idle();
    check("clean_rd_cnt",   32'(rd_cnt),   32'd16);
    check("clean_rd_first", 32'(rd_first), 32'd0);
    check("clean_rd_seq",   32'(seq_err),  32'd0);
    check("clean_wr_cnt",   32'(wr_cnt),   32'd0);
    check("clean_pd_cnt",   32'(pd_cnt),   32'd1);
    check("clean_ce",       32'(ce_cnt_o), 32'd0);
    check("clean_ue",       32'(ue_cnt_o), 32'd0);

    // Single-bit error at address 5
    clear_log();
    err1[5] = 1'b1; fix_data[5] = 4'hA;
    en_i = 1'b1;
    wait_pass("ce");
    go_idle();
    check("ce_wr_cnt",  32'(wr_cnt),      32'd1);
    check("ce_wr_addr", 32'(wr_addr),     32'd5);
    check("ce_wr_data", 32'(wr_data),     32'hA);
    check("ce_wdata",   32'(mem_wdata_o), 32'hA);
    check("ce_ce_cnt",  32'(ce_cnt_o),    32'd1);
    check("ce_ue_cnt",  32'(ue_cnt_o),    32'd0);
    check("ce_rd_cnt",  32'(rd_cnt),      32'd16);
    err1 = '0;
    pulse_clr();
    check("clr_ce", 32'(ce_cnt_o), 32'd0);

    // Double-bit errors at 3 (both flags) and 9
    clear_log();
    err1[3] = 1'b1; err2[3] = 1'b1; err2[9] = 1'b1;
    en_i = 1'b1;
    wait_pass("ue");
    go_idle();
    check("ue_cnt",      32'(ue_cnt_o),   32'd2);
    check("ue_addr",     32'(ue_addr_o),  32'd3);
    check("ue_valid",    32'(ue_valid_o), 32'd1);
    check("ue_irq",      32'(irq_o),      32'd1);
    check("ue_no_wr",    32'(wr_cnt),     32'd0);
    check("ue_ce_cnt",   32'(ce_cnt_o),   32'd0);
    pulse_clr();
    check("ue_clr_cnt",   32'(ue_cnt_o),   32'd0);
    check("ue_clr_valid", 32'(ue_valid_o), 32'd0);
    check("ue_clr_addr",  32'(ue_addr_o),  32'd0);
    check("ue_clr_irq",   32'(irq_o),      32'd0);
    err1 = '0; err2 = '0;

    // Backpressure: 5 stall cycles on every read and the write
    gnt_wait = 5;
    clear_log();
    err1[6] = 1'b1; fix_data[6] = 4'h5;
    en_i = 1'b1;
    wait_pass("bp");
    go_idle();
    check("bp_stall_cnt", 32'(stall_cnt), 32'd85);
    check("bp_stable",    32'(stab_err),  32'd0);
    check("bp_rd_cnt",    32'(rd_cnt),    32'd16);
    check("bp_rd_seq",    32'(seq_err),   32'd0);
    check("bp_wr_cnt",    32'(wr_cnt),    32'd1);
    check("bp_wr_addr",   32'(wr_addr),   32'd6);
    check("bp_wr_data",   32'(wr_data),   32'h5);
    err1 = '0;
    pulse_clr();

    // Enable drop while the writeback at address 7 is stalled
    clear_log();
    err1[7] = 1'b1; fix_data[7] = 4'hC;
    en_i = 1'b1;
    wait_for_write("drop_wr_seen");
    check("drop_wr_addr_live", 32'(mem_addr_o), 32'd7);
    en_i = 1'b0;
    repeat (20) @(negedge clk);
    check("drop_wr_cnt",  32'(wr_cnt),     32'd1);
    check("drop_wr_addr", 32'(wr_addr),    32'd7);
    check("drop_wr_data", 32'(wr_data),    32'hC);
    check("drop_rd_cnt",  32'(rd_cnt),     32'd8);
    check("drop_no_pd",   32'(pd_cnt),     32'd0);
    check("drop_busy",    32'(busy_o),     32'd0);
    check("drop_addr0",   32'(mem_addr_o), 32'd0);
    err1 = '0; gnt_wait = 0;
    pulse_clr();

    // Restart with start_i skipping the interval
    clear_log();
    en_i = 1'b1;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("start_req",  32'(mem_req_o),  32'd1);
    check("start_addr", 32'(mem_addr_o), 32'd0);
    wait_pass("restart");
    go_idle();
    check("restart_rd_first", 32'(rd_first), 32'd0);
    check("restart_rd_cnt",   32'(rd_cnt),   32'd16);

    // Saturation: four correctable errors into a 2-bit counter
    clear_log();
    err1 = 16'h0116;
    en_i = 1'b1;
    wait_pass("sat");
    go_idle();
    check("sat_ce",     32'(ce_cnt_o), 32'd3);
    check("sat_wr_cnt", 32'(wr_cnt),   32'd4);

    // clr_i on the same cycle as the error at address 2, then one more at address 5
    clear_log();
    err1 = 16'h0024;
    en_i = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      found = mem_req_o && !mem_we_o && (mem_addr_o == 4'd2);
    end
    check("prio_rd2_seen", 32'(found), 32'd1);
    @(negedge clk);
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    wait_pass("prio");
    go_idle();
    check("prio_ce",     32'(ce_cnt_o), 32'd1);
    check("prio_wr_cnt", 32'(wr_cnt),   32'd2);
    err1 = '0;

    // Asynchronous reset while a read request is pending
    gnt_wait = 5;
    en_i = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      found = mem_req_o;
    end
    check("arst_req_seen", 32'(found), 32'd1);
    rst_ni = 1'b0;
    #1;
    check("arst_req",  32'(mem_req_o), 32'd0);
    check("arst_busy", 32'(busy_o),    32'd0);
    check("arst_ce",   32'(ce_cnt_o),  32'd0);
    en_i = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
